// File: rtl/hqm_aw_tx_sync_mc_pkg.sv
// Shared limits and the round-robin pick helper for the multi-channel tx sync buffer.
package hqm_aw_tx_sync_mc_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_DEPTH = 8;
    localparam int IDX_W     = $clog2(MAX_CH);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rr_grant_t;

    // Scans req from ptr upward over n channels, wrapping; lowest offset wins.
    function automatic rr_grant_t rr_pick(input logic [MAX_CH-1:0] req,
                                          input logic [IDX_W-1:0]  ptr,
                                          input int unsigned       n);
        rr_grant_t   g;
        int unsigned idx;
        g = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % n;
            if ((i < int'(n)) && req[idx]) begin
                g.vld = 1'b1;
                g.idx = idx[IDX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/hqm_aw_tx_sync_mc_fifo.sv
// Per-channel DEPTH-entry FIFO: regfile, wrapping pointers, occupancy counter.
module hqm_aw_tx_sync_mc_fifo
    import hqm_aw_tx_sync_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (occ == CNT_W'(DEPTH));
    assign empty   = (occ == '0);
    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                occ <= occ + 1'b1;
            end else if (!do_push && do_pop) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hqm_aw_tx_sync_mc.sv
// Multi-channel tx sync buffer: per-channel FIFOs merged by a round-robin arbiter.
// Define HQM_AW_TX_SYNC_MC_PRIO_EN to give channel 0 strict priority over the RR group.
module hqm_aw_tx_sync_mc
    import hqm_aw_tx_sync_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    hqm_gated_clk,
    input  logic                    hqm_gated_rst,
    input  logic                    rst_prep,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic [NUM_CH*CNT_W-1:0] occupancy,
    output logic [2:0]              status,
    output logic                    idle
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_CH];
    logic [CNT_W-1:0]  occ  [NUM_CH];

    logic              any_full;
    logic              any_nonempty;
    logic              fire;
    logic              err_sticky;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_ch;
    logic              rr_adv;
    logic [MAX_CH-1:0] req_ext;
    rr_grant_t         pick;

    // Grant captured while the output is stalled so a late-arriving channel
    // cannot displace the word already presented.
    logic              hold_vld;
    logic [CH_W-1:0]   hold_ch;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            hqm_aw_tx_sync_mc_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clk   (hqm_gated_clk),
                .rst   (hqm_gated_rst),
                .push  (push[c]),
                .pop   (pop[c]),
                .wdata (in_data[c*WIDTH +: WIDTH]),
                .rdata (head[c]),
                .occ   (occ[c]),
                .full  (full[c]),
                .empty (empty[c])
            );
            assign occupancy[c*CNT_W +: CNT_W] = occ[c];
        end
    endgenerate

    assign nonempty     = ~empty;
    assign any_full     = |full;
    assign any_nonempty = |nonempty;

    // in_ready depends only on registered occupancy and rst_prep.
    assign in_ready = ~full & {NUM_CH{!rst_prep}};
    assign push     = in_valid & in_ready;

    always_comb begin
        req_ext             = '0;
        req_ext[NUM_CH-1:0] = nonempty;
        pick                = '0;
        rr_adv              = 1'b1;
`ifdef HQM_AW_TX_SYNC_MC_PRIO_EN
        if (nonempty[0]) begin
            pick.vld = 1'b1;
            pick.idx = '0;
            rr_adv   = 1'b0;
        end else begin
            pick = rr_pick(req_ext & ~MAX_CH'(1), IDX_W'(rr_ptr), NUM_CH);
        end
`else
        pick = rr_pick(req_ext, IDX_W'(rr_ptr), NUM_CH);
`endif
        grant_ch = hold_vld ? hold_ch : CH_W'(pick.idx % NUM_CH);
    end

    assign out_valid = pick.vld && !rst_prep;
    assign out_ch    = grant_ch;
    assign out_data  = head[grant_ch];
    assign fire      = out_valid && out_ready;

    always_comb begin
        pop = '0;
        if (fire) begin
            pop[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge hqm_gated_clk) begin
        if (hqm_gated_rst) begin
            rr_ptr     <= '0;
            err_sticky <= 1'b0;
            hold_vld   <= 1'b0;
            hold_ch    <= '0;
        end else begin
            if (fire && (!hold_vld || rr_adv || grant_ch != '0)) begin
`ifdef HQM_AW_TX_SYNC_MC_PRIO_EN
                if (grant_ch != '0) begin
                    rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
                end
`else
                rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
`endif
            end
            err_sticky <= err_sticky | (rst_prep && |in_valid);
            hold_vld   <= out_valid && !out_ready;
            hold_ch    <= grant_ch;
        end
    end

    assign status = {err_sticky, any_full, any_nonempty};
    assign idle   = !any_nonempty && !rst_prep;

endmodule

// File: tb/tb_hqm_aw_tx_sync_mc.sv
// Directed bench for hqm_aw_tx_sync_mc (NUM_CH=4, WIDTH=32, DEPTH=2).
module tb_hqm_aw_tx_sync_mc;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 2;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 2;

    logic                    clk;
    logic                    rst;
    logic                    rst_prep;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic [NUM_CH*CNT_W-1:0] occupancy;
    logic [2:0]              status;
    logic                    idle;

    int total;
    int bad;

    hqm_aw_tx_sync_mc #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .hqm_gated_clk (clk),
        .hqm_gated_rst (rst),
        .rst_prep      (rst_prep),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .occupancy     (occupancy),
        .status        (status),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rst_prep  = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [CH_W-1:0]  exp_ch6 [4];
    logic [WIDTH-1:0] exp_d6  [4];

    initial begin
        total = 0;
        bad   = 0;

        // 1: reset state
        do_reset();
        chk("rst_in_ready",  32'(in_ready),  32'hF);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occ",       32'(occupancy), 32'h0);
        chk("rst_idle",      32'(idle),      32'h1);
        chk("rst_status",    32'(status),    32'h0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_out_ch",    32'(out_ch),    32'h0);

        // 2: ch1 fills, third push stalls, output stable
        in_valid = 4'b0010;
        set_data(1, 32'hA);
        tick();
        chk("t2_lat_valid", 32'(out_valid), 32'h1);
        chk("t2_lat_data",  out_data,       32'hA);
        set_data(1, 32'hB);
        tick();
        chk("t2_occ",      32'(occupancy), 32'h08);
        chk("t2_in_ready", 32'(in_ready),  32'hD);
        chk("t2_status",   32'(status),    32'h3);
        set_data(1, 32'hC);
        tick();
        tick();
        chk("t2_occ_stall", 32'(occupancy), 32'h08);
        chk("t2_data_hold", out_data,       32'hA);
        chk("t2_ch_hold",   32'(out_ch),    32'h1);
        in_valid  = '0;
        out_ready = 1'b1;
        #1;
        chk("t2_pop_a", out_data, 32'hA);
        tick();
        chk("t2_pop_b", out_data, 32'hB);
        tick();
        chk("t2_drained", 32'(idle), 32'h1);

        // mid-operation reset discards buffered words
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        set_data(0, 32'h77);
        tick();
        do_reset();
        chk("midrst_occ",   32'(occupancy), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);

        // 3: all channels full, round-robin drain
        in_valid = 4'hF;
        for (int ch = 0; ch < NUM_CH; ch++) set_data(ch, 32'h100 * ch);
        tick();
        for (int ch = 0; ch < NUM_CH; ch++) set_data(ch, 32'h100 * ch + 1);
        tick();
        chk("t3_occ_full", 32'(occupancy), 32'hAA);
        chk("t3_in_ready", 32'(in_ready),  32'h0);
        chk("t3_status",   32'(status),    32'h3);
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t3_ch%0d", k),   32'(out_ch), 32'(k % 4));
            chk($sformatf("t3_data%0d", k), out_data,    32'h100 * (k % 4) + (k / 4));
            tick();
        end
        chk("t3_occ_empty", 32'(occupancy), 32'h0);
        chk("t3_idle",      32'(idle),      32'h1);

        // 4: full ch2 push+pop refused, then push+pop at occ=1
        do_reset();
        in_valid = 4'b0100;
        set_data(2, 32'h20);
        tick();
        set_data(2, 32'h21);
        tick();
        set_data(2, 32'h22);
        out_ready = 1'b1;
        #1;
        chk("t4_ready_full", 32'(in_ready), 32'hB);
        chk("t4_head0",      out_data,      32'h20);
        tick();
        chk("t4_occ_dec", 32'(occupancy), 32'h10);
        set_data(2, 32'h23);
        #1;
        chk("t4_head1", out_data, 32'h21);
        tick();
        chk("t4_occ_same", 32'(occupancy), 32'h10);
        chk("t4_head2",    out_data,       32'h23);
        in_valid = '0;
        tick();
        chk("t4_empty", 32'(occupancy), 32'h0);

        // 5: rst_prep masks I/O, keeps contents, sets err_sticky
        do_reset();
        in_valid = 4'b1011;
        set_data(0, 32'h50);
        set_data(1, 32'h51);
        set_data(3, 32'h53);
        tick();
        chk("t5_occ", 32'(occupancy), 32'h45);
        rst_prep = 1'b1;
        in_valid = 4'b0001;
        set_data(0, 32'h5F);
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'h0);
        chk("t5_in_ready",  32'(in_ready),  32'h0);
        chk("t5_idle",      32'(idle),      32'h0);
        tick();
        chk("t5_err",      32'(status[2]), 32'h1);
        chk("t5_occ_kept", 32'(occupancy), 32'h45);
        rst_prep  = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        #1;
        chk("t5_d0", out_data, 32'h50);
        tick();
        chk("t5_d1", out_data, 32'h51);
        tick();
        chk("t5_d2",  out_data,       32'h53);
        chk("t5_ch2", 32'(out_ch),    32'h3);
        tick();
        chk("t5_status_after", 32'(status), 32'h4);
        chk("t5_idle_after",   32'(idle),   32'h1);
        do_reset();
        chk("t5_err_cleared", 32'(status), 32'h0);

        // 6: ch0 and ch3 both loaded
`ifdef HQM_AW_TX_SYNC_MC_PRIO_EN
        exp_ch6 = '{2'd0, 2'd0, 2'd3, 2'd3};
        exp_d6  = '{32'h60, 32'h61, 32'h30, 32'h31};
`else
        exp_ch6 = '{2'd0, 2'd3, 2'd0, 2'd3};
        exp_d6  = '{32'h60, 32'h30, 32'h61, 32'h31};
`endif
        in_valid = 4'b1001;
        set_data(0, 32'h60);
        set_data(3, 32'h30);
        tick();
        set_data(0, 32'h61);
        set_data(3, 32'h31);
        tick();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t6_ch%0d", k),   32'(out_ch), 32'(exp_ch6[k]));
            chk($sformatf("t6_data%0d", k), out_data,    exp_d6[k]);
            tick();
        end
        chk("t6_idle", 32'(idle), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
